// File: rtl/exe_wb_arbiter_if.sv
`timescale 1ns/1ps
// exe_wb_arbiter_if
// Groups the four producer result channels and the two writeback ports that
// sit between the execution stage and the writeback arbiter.
//   Producer channels (mult, alu1, alu2, ld): *_vld, *_data, *_idx toward the
//     arbiter; *_rdy back to the producer.
//   Writeback ports (wb0, wb1): *_vld, *_data, *_idx, *_src toward the
//     register file / reorder logic.
// Modports:
//   master : the upstream side (drives results, observes rdy and writeback)
//   slave  : the arbiter (consumes results, drives rdy and writeback)
interface exe_wb_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 6
);
  logic              mult_vld;
  logic [DATA_W-1:0] mult_data;
  logic [IDX_W-1:0]  mult_idx;
  logic              mult_rdy;

  logic              alu1_vld;
  logic [DATA_W-1:0] alu1_data;
  logic [IDX_W-1:0]  alu1_idx;
  logic              alu1_rdy;

  logic              alu2_vld;
  logic [DATA_W-1:0] alu2_data;
  logic [IDX_W-1:0]  alu2_idx;
  logic              alu2_rdy;

  logic              ld_vld;
  logic [DATA_W-1:0] ld_data;
  logic [IDX_W-1:0]  ld_idx;
  logic              ld_rdy;

  logic              wb0_vld;
  logic [DATA_W-1:0] wb0_data;
  logic [IDX_W-1:0]  wb0_idx;
  logic [1:0]        wb0_src;

  logic              wb1_vld;
  logic [DATA_W-1:0] wb1_data;
  logic [IDX_W-1:0]  wb1_idx;
  logic [1:0]        wb1_src;

  modport master (
    output mult_vld, mult_data, mult_idx, input mult_rdy,
    output alu1_vld, alu1_data, alu1_idx, input alu1_rdy,
    output alu2_vld, alu2_data, alu2_idx, input alu2_rdy,
    output ld_vld,   ld_data,   ld_idx,   input ld_rdy,
    input  wb0_vld, wb0_data, wb0_idx, wb0_src,
    input  wb1_vld, wb1_data, wb1_idx, wb1_src
  );

  modport slave (
    input  mult_vld, mult_data, mult_idx, output mult_rdy,
    input  alu1_vld, alu1_data, alu1_idx, output alu1_rdy,
    input  alu2_vld, alu2_data, alu2_idx, output alu2_rdy,
    input  ld_vld,   ld_data,   ld_idx,   output ld_rdy,
    output wb0_vld, wb0_data, wb0_idx, wb0_src,
    output wb1_vld, wb1_data, wb1_idx, wb1_src
  );
endinterface

// File: rtl/exe_wb_arbiter.sv
`timescale 1ns/1ps
// exe_wb_arbiter
// Writeback arbiter behind the execution stage. Each of the four producers
// (0=mult, 1=alu1, 2=alu2, 3=ld) owns a one-entry holder. Every cycle a
// round-robin scan over the full holders picks up to two of them; the picks
// are registered onto writeback ports wb0/wb1 on the next edge.
// Ports:
//   clk        : system clock
//   rst        : synchronous reset, active-low
//   bus        : slave side of exe_wb_arbiter_if (producer channels + wb ports)
//   rr_ptr_dbg : current round-robin start source
//   full_dbg   : holder full bits, bit n = source n
//
// Handshake: a producer result transfers on a rising clk edge where *_vld and
// *_rdy are both 1. *_rdy depends only on holder state and this cycle's grant,
// never on *_vld. While *_rdy is 0 the producer must keep *_vld and its
// payload stable. wb*_vld is a one-cycle pulse per result with no back-pressure.
module exe_wb_arbiter #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 6
) (
  input  logic             clk,
  input  logic             rst,
  exe_wb_arbiter_if.slave  bus,
  output logic [1:0]       rr_ptr_dbg,
  output logic [3:0]       full_dbg
);

  // Flattened producer channels, indexed by source id.
  logic [3:0]        in_vld;
  logic [DATA_W-1:0] in_data [4];
  logic [IDX_W-1:0]  in_idx  [4];

  assign in_vld     = {bus.ld_vld, bus.alu2_vld, bus.alu1_vld, bus.mult_vld};
  assign in_data[0] = bus.mult_data;
  assign in_data[1] = bus.alu1_data;
  assign in_data[2] = bus.alu2_data;
  assign in_data[3] = bus.ld_data;
  assign in_idx[0]  = bus.mult_idx;
  assign in_idx[1]  = bus.alu1_idx;
  assign in_idx[2]  = bus.alu2_idx;
  assign in_idx[3]  = bus.ld_idx;

  // Holders and arbitration state.
  logic [3:0]        full_q;
  logic [DATA_W-1:0] data_q [4];
  logic [IDX_W-1:0]  idx_q  [4];
  logic [1:0]        rr_ptr;

  // Registered writeback ports.
  logic              wb0_vld_q, wb1_vld_q;
  logic [DATA_W-1:0] wb0_data_q, wb1_data_q;
  logic [IDX_W-1:0]  wb0_idx_q, wb1_idx_q;
  logic [1:0]        wb0_src_q, wb1_src_q;

  // Arbitration results for this cycle.
  logic              have_a, have_b;
  logic [1:0]        gnt_a, gnt_b;
  logic [3:0]        gnt_vec;
  logic [1:0]        scan_src;
  logic [1:0]        rr_ptr_nxt;
  logic [3:0]        rdy;
  logic [3:0]        accept;

  // Scan rr_ptr, rr_ptr+1, ... (mod 4). First full holder goes to port 0,
  // the next full one to port 1.
  always_comb begin
    have_a   = 1'b0;
    have_b   = 1'b0;
    gnt_a    = 2'd0;
    gnt_b    = 2'd0;
    gnt_vec  = 4'd0;
    scan_src = 2'd0;
    for (int k = 0; k < 4; k++) begin
      scan_src = rr_ptr + k[1:0];
      if (full_q[scan_src]) begin
        if (!have_a) begin
          have_a = 1'b1;
          gnt_a  = scan_src;
        end else if (!have_b) begin
          have_b = 1'b1;
          gnt_b  = scan_src;
        end
      end
    end
    if (have_a) gnt_vec[gnt_a] = 1'b1;
    if (have_b) gnt_vec[gnt_b] = 1'b1;
  end

  // Pointer moves past the last source served, so a served source drops to
  // the back of the order and any full holder is reached within two cycles.
  always_comb begin
    rr_ptr_nxt = rr_ptr;
    if (have_b)      rr_ptr_nxt = gnt_b + 2'd1;
    else if (have_a) rr_ptr_nxt = gnt_a + 2'd1;
  end

  // A holder being drained this cycle can take a new entry on the same edge.
  assign rdy    = ~full_q | gnt_vec;
  assign accept = in_vld & rdy;

  always_ff @(posedge clk) begin
    if (!rst) begin
      full_q     <= 4'd0;
      rr_ptr     <= 2'd0;
      wb0_vld_q  <= 1'b0;
      wb1_vld_q  <= 1'b0;
      wb0_data_q <= '0;
      wb1_data_q <= '0;
      wb0_idx_q  <= '0;
      wb1_idx_q  <= '0;
      wb0_src_q  <= 2'd0;
      wb1_src_q  <= 2'd0;
      for (int s = 0; s < 4; s++) begin
        data_q[s] <= '0;
        idx_q[s]  <= '0;
      end
    end else begin
      for (int s = 0; s < 4; s++) begin
        if (accept[s]) begin
          full_q[s] <= 1'b1;
          data_q[s] <= in_data[s];
          idx_q[s]  <= in_idx[s];
        end else if (gnt_vec[s]) begin
          full_q[s] <= 1'b0;
        end
      end
      rr_ptr    <= rr_ptr_nxt;
      wb0_vld_q <= have_a;
      wb1_vld_q <= have_b;
      // Payload only updates on a grant so idle ports keep their last value.
      if (have_a) begin
        wb0_data_q <= data_q[gnt_a];
        wb0_idx_q  <= idx_q[gnt_a];
        wb0_src_q  <= gnt_a;
      end
      if (have_b) begin
        wb1_data_q <= data_q[gnt_b];
        wb1_idx_q  <= idx_q[gnt_b];
        wb1_src_q  <= gnt_b;
      end
    end
  end

  assign bus.mult_rdy = rdy[0];
  assign bus.alu1_rdy = rdy[1];
  assign bus.alu2_rdy = rdy[2];
  assign bus.ld_rdy   = rdy[3];

  assign bus.wb0_vld  = wb0_vld_q;
  assign bus.wb0_data = wb0_data_q;
  assign bus.wb0_idx  = wb0_idx_q;
  assign bus.wb0_src  = wb0_src_q;
  assign bus.wb1_vld  = wb1_vld_q;
  assign bus.wb1_data = wb1_data_q;
  assign bus.wb1_idx  = wb1_idx_q;
  assign bus.wb1_src  = wb1_src_q;

  assign rr_ptr_dbg = rr_ptr;
  assign full_dbg   = full_q;

endmodule

// File: tb/tb_exe_wb_arbiter.sv
`timescale 1ns/1ps
// tb_exe_wb_arbiter
// Directed bench for exe_wb_arbiter: reset values, single result latency,
// four-way collision ordering, sustained fairness, same-edge replace,
// reset with buffered results, and idle behaviour.
module tb_exe_wb_arbiter;
  localparam int DATA_W = 16;
  localparam int IDX_W  = 6;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  logic [1:0] rr_ptr_dbg;
  logic [3:0] full_dbg;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exe_wb_arbiter_if #(.DATA_W(DATA_W), .IDX_W(IDX_W)) bus ();

  exe_wb_arbiter #(.DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .rr_ptr_dbg (rr_ptr_dbg),
    .full_dbg   (full_dbg)
  );

  int pass_cnt  = 0;
  int check_cnt = 0;

  // Expected writeback data, in order, for the replace scenario.
  logic [DATA_W-1:0] exp_q[$];

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int s, input logic v, input logic [DATA_W-1:0] d,
                         input logic [IDX_W-1:0] ix);
    case (s)
      0: begin bus.mult_vld = v; bus.mult_data = d; bus.mult_idx = ix; end
      1: begin bus.alu1_vld = v; bus.alu1_data = d; bus.alu1_idx = ix; end
      2: begin bus.alu2_vld = v; bus.alu2_data = d; bus.alu2_idx = ix; end
      default: begin bus.ld_vld = v; bus.ld_data = d; bus.ld_idx = ix; end
    endcase
  endtask

  task automatic clear_inputs();
    for (int s = 0; s < 4; s++) set_src(s, 1'b0, '0, '0);
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    check_cnt++; if (bus.wb0_vld !== 1'b0) $display("FAIL rst_wb0_vld got %b exp 0", bus.wb0_vld); else pass_cnt++;
    check_cnt++; if (bus.wb1_vld !== 1'b0) $display("FAIL rst_wb1_vld got %b exp 0", bus.wb1_vld); else pass_cnt++;
    check_cnt++; if (bus.wb0_data !== 16'h0) $display("FAIL rst_wb0_data got %h exp 0", bus.wb0_data); else pass_cnt++;
    check_cnt++; if (bus.wb1_idx !== 6'h0) $display("FAIL rst_wb1_idx got %h exp 0", bus.wb1_idx); else pass_cnt++;
    check_cnt++; if (bus.wb0_src !== 2'd0) $display("FAIL rst_wb0_src got %0d exp 0", bus.wb0_src); else pass_cnt++;
    check_cnt++; if (rr_ptr_dbg !== 2'd0) $display("FAIL rst_rr_ptr got %0d exp 0", rr_ptr_dbg); else pass_cnt++;
    check_cnt++; if (full_dbg !== 4'b0000) $display("FAIL rst_full got %b exp 0000", full_dbg); else pass_cnt++;
    check_cnt++;
    if ({bus.ld_rdy, bus.alu2_rdy, bus.alu1_rdy, bus.mult_rdy} !== 4'b1111)
      $display("FAIL rst_rdy got %b exp 1111", {bus.ld_rdy, bus.alu2_rdy, bus.alu1_rdy, bus.mult_rdy});
    else pass_cnt++;
  endtask

  task automatic test_single();
    do_reset();
    set_src(1, 1'b1, 16'h1234, 6'd5);
    check_cnt++; if (bus.alu1_rdy !== 1'b1) $display("FAIL single_rdy_empty got %b exp 1", bus.alu1_rdy); else pass_cnt++;
    tick();  // accept edge
    clear_inputs();
    check_cnt++; if (bus.wb0_vld !== 1'b0) $display("FAIL single_early_vld got %b exp 0", bus.wb0_vld); else pass_cnt++;
    check_cnt++; if (full_dbg !== 4'b0010) $display("FAIL single_full got %b exp 0010", full_dbg); else pass_cnt++;
    check_cnt++; if (bus.alu1_rdy !== 1'b1) $display("FAIL single_rdy_granted got %b exp 1", bus.alu1_rdy); else pass_cnt++;
    tick();  // grant edge
    check_cnt++; if (bus.wb0_vld !== 1'b1) $display("FAIL single_wb0_vld got %b exp 1", bus.wb0_vld); else pass_cnt++;
    check_cnt++; if (bus.wb0_data !== 16'h1234) $display("FAIL single_wb0_data got %h exp 1234", bus.wb0_data); else pass_cnt++;
    check_cnt++; if (bus.wb0_idx !== 6'd5) $display("FAIL single_wb0_idx got %0d exp 5", bus.wb0_idx); else pass_cnt++;
    check_cnt++; if (bus.wb0_src !== 2'd1) $display("FAIL single_wb0_src got %0d exp 1", bus.wb0_src); else pass_cnt++;
    check_cnt++; if (bus.wb1_vld !== 1'b0) $display("FAIL single_wb1_vld got %b exp 0", bus.wb1_vld); else pass_cnt++;
    check_cnt++; if (rr_ptr_dbg !== 2'd2) $display("FAIL single_rr_ptr got %0d exp 2", rr_ptr_dbg); else pass_cnt++;
    tick();
    check_cnt++; if (bus.wb0_vld !== 1'b0) $display("FAIL single_pulse got %b exp 0", bus.wb0_vld); else pass_cnt++;
    check_cnt++; if (bus.wb0_data !== 16'h1234) $display("FAIL single_hold_data got %h exp 1234", bus.wb0_data); else pass_cnt++;
  endtask

  task automatic test_all_four();
    do_reset();
    for (int s = 0; s < 4; s++) set_src(s, 1'b1, 16'(s + 1), 6'(s + 10));
    tick();  // all four accepted
    clear_inputs();
    check_cnt++;
    if ({bus.ld_rdy, bus.alu2_rdy, bus.alu1_rdy, bus.mult_rdy} !== 4'b0011)
      $display("FAIL four_rdy got %b exp 0011", {bus.ld_rdy, bus.alu2_rdy, bus.alu1_rdy, bus.mult_rdy});
    else pass_cnt++;
    tick();
    check_cnt++; if ({bus.wb0_vld, bus.wb1_vld} !== 2'b11) $display("FAIL four_c1_vld got %b exp 11", {bus.wb0_vld, bus.wb1_vld}); else pass_cnt++;
    check_cnt++; if (bus.wb0_data !== 16'h0001 || bus.wb0_src !== 2'd0 || bus.wb0_idx !== 6'd10)
      $display("FAIL four_c1_wb0 got %h/%0d/%0d exp 0001/0/10", bus.wb0_data, bus.wb0_src, bus.wb0_idx); else pass_cnt++;
    check_cnt++; if (bus.wb1_data !== 16'h0002 || bus.wb1_src !== 2'd1 || bus.wb1_idx !== 6'd11)
      $display("FAIL four_c1_wb1 got %h/%0d/%0d exp 0002/1/11", bus.wb1_data, bus.wb1_src, bus.wb1_idx); else pass_cnt++;
    check_cnt++; if (rr_ptr_dbg !== 2'd2) $display("FAIL four_rr_ptr got %0d exp 2", rr_ptr_dbg); else pass_cnt++;
    tick();
    check_cnt++; if ({bus.wb0_vld, bus.wb1_vld} !== 2'b11) $display("FAIL four_c2_vld got %b exp 11", {bus.wb0_vld, bus.wb1_vld}); else pass_cnt++;
    check_cnt++; if (bus.wb0_data !== 16'h0003 || bus.wb0_src !== 2'd2)
      $display("FAIL four_c2_wb0 got %h/%0d exp 0003/2", bus.wb0_data, bus.wb0_src); else pass_cnt++;
    check_cnt++; if (bus.wb1_data !== 16'h0004 || bus.wb1_src !== 2'd3)
      $display("FAIL four_c2_wb1 got %h/%0d exp 0004/3", bus.wb1_data, bus.wb1_src); else pass_cnt++;
    tick();
    check_cnt++; if ({bus.wb0_vld, bus.wb1_vld} !== 2'b00) $display("FAIL four_drained got %b exp 00", {bus.wb0_vld, bus.wb1_vld}); else pass_cnt++;
  endtask

  task automatic test_fairness();
    int cnt [4];
    int last [4];
    do_reset();
    for (int s = 0; s < 4; s++) begin
      cnt[s]  = 0;
      last[s] = -1;
      set_src(s, 1'b1, 16'(16'h0100 + s), 6'(s + 20));
    end
    tick();  // first accept edge; nothing on the ports yet
    // Eight output cycles; inputs stay valid through the eighth accept edge.
    for (int c = 0; c < 8; c++) begin
      tick();
      if (c == 6) clear_inputs();
      check_cnt++;
      if (bus.wb0_vld && bus.wb1_vld && bus.wb0_src === bus.wb1_src)
        $display("FAIL fair_same_src cycle %0d got %0d on both ports exp distinct", c, bus.wb0_src);
      else pass_cnt++;
      if (bus.wb0_vld) begin
        check_cnt++;
        if (c - last[bus.wb0_src] > 2)
          $display("FAIL fair_wait src %0d got gap %0d exp <=2", bus.wb0_src, c - last[bus.wb0_src]);
        else pass_cnt++;
        cnt[bus.wb0_src]++;
        last[bus.wb0_src] = c;
      end
      if (bus.wb1_vld) begin
        check_cnt++;
        if (c - last[bus.wb1_src] > 2)
          $display("FAIL fair_wait src %0d got gap %0d exp <=2", bus.wb1_src, c - last[bus.wb1_src]);
        else pass_cnt++;
        cnt[bus.wb1_src]++;
        last[bus.wb1_src] = c;
      end
    end
    for (int s = 0; s < 4; s++) begin
      check_cnt++;
      if (cnt[s] != 4) $display("FAIL fair_count src %0d got %0d exp 4", s, cnt[s]);
      else pass_cnt++;
    end
    for (int d = 0; d < 3; d++) tick();
    check_cnt++; if (full_dbg !== 4'b0000) $display("FAIL fair_drain_full got %b exp 0000", full_dbg); else pass_cnt++;
  endtask

  task automatic test_replace();
    logic [DATA_W-1:0] exp_d;
    do_reset();
    exp_q.delete();
    exp_q.push_back(16'd10);
    exp_q.push_back(16'd11);
    exp_q.push_back(16'd12);
    set_src(0, 1'b1, 16'd10, 6'd1);
    check_cnt++; if (bus.mult_rdy !== 1'b1) $display("FAIL repl_rdy0 got %b exp 1", bus.mult_rdy); else pass_cnt++;
    tick();  // 10 accepted
    check_cnt++; if (bus.wb0_vld !== 1'b0) $display("FAIL repl_early got %b exp 0", bus.wb0_vld); else pass_cnt++;
    // Each following cycle the holder is full and granted, so 11 and 12 replace on the same edge.
    for (int i = 1; i <= 3; i++) begin
      if (i < 3) begin
        set_src(0, 1'b1, 16'(10 + i), 6'(1 + i));
        check_cnt++; if (bus.mult_rdy !== 1'b1) $display("FAIL repl_rdy%0d got %b exp 1", i, bus.mult_rdy); else pass_cnt++;
      end else begin
        clear_inputs();
      end
      tick();
      exp_d = exp_q.pop_front();
      check_cnt++;
      if (bus.wb0_vld !== 1'b1 || bus.wb0_data !== exp_d)
        $display("FAIL repl_out%0d got vld %b data %0d exp vld 1 data %0d", i, bus.wb0_vld, bus.wb0_data, exp_d);
      else pass_cnt++;
      check_cnt++; if (bus.wb1_vld !== 1'b0) $display("FAIL repl_wb1_%0d got %b exp 0", i, bus.wb1_vld); else pass_cnt++;
      if (i < 3) begin
        check_cnt++; if (full_dbg[0] !== 1'b1) $display("FAIL repl_full%0d got %b exp 1", i, full_dbg[0]); else pass_cnt++;
      end
    end
    tick();
    check_cnt++; if (bus.wb0_vld !== 1'b0) $display("FAIL repl_no_dup got %b exp 0", bus.wb0_vld); else pass_cnt++;
    check_cnt++; if (exp_q.size() != 0) $display("FAIL repl_queue got %0d left exp 0", exp_q.size()); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    // Leaves rr_ptr away from zero (test_replace ends pointing past mult).
    for (int s = 0; s < 3; s++) set_src(s, 1'b1, 16'(16'h0AA0 + s), 6'(s + 30));
    tick();  // three holders loaded
    clear_inputs();
    check_cnt++; if (full_dbg !== 4'b0111) $display("FAIL mid_loaded got %b exp 0111", full_dbg); else pass_cnt++;
    rst = 1'b0;
    tick();  // reset edge before any grant registers
    rst = 1'b1;
    check_cnt++; if (full_dbg !== 4'b0000) $display("FAIL mid_full got %b exp 0000", full_dbg); else pass_cnt++;
    check_cnt++; if (rr_ptr_dbg !== 2'd0) $display("FAIL mid_rr_ptr got %0d exp 0", rr_ptr_dbg); else pass_cnt++;
    for (int c = 0; c < 4; c++) begin
      check_cnt++;
      if ({bus.wb0_vld, bus.wb1_vld} !== 2'b00)
        $display("FAIL mid_no_wb cycle %0d got %b exp 00", c, {bus.wb0_vld, bus.wb1_vld});
      else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_idle();
    clear_inputs();
    for (int c = 0; c < 5; c++) begin
      tick();
      check_cnt++;
      if ({bus.wb0_vld, bus.wb1_vld} !== 2'b00)
        $display("FAIL idle_vld cycle %0d got %b exp 00", c, {bus.wb0_vld, bus.wb1_vld});
      else pass_cnt++;
      check_cnt++; if (rr_ptr_dbg !== 2'd0) $display("FAIL idle_rr_ptr cycle %0d got %0d exp 0", c, rr_ptr_dbg); else pass_cnt++;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b0;
    clear_inputs();
    test_reset();
    test_single();
    test_all_four();
    test_fairness();
    test_replace();
    test_reset_mid();
    test_idle();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no completion exp finish before 200000ns");
    $fatal(1, "timeout");
  end

endmodule
